clk_div_prog: RTL and testbench



---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_cfg.sv | 58 +++++
 rtl/clk_div_prog.sv | 102 ++++++++++
 tb/tb_clk_div_prog.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int MIN_DIV   = 2;

    // Divisors 0 and 1 cannot produce a toggling clock.
    function automatic logic div_legal(input logic [31:0] value);
        return (value >= 32'(MIN_DIV));
    endfunction

    // High time in whole clk cycles: floor(N/2).
    function automatic logic [31:0] high_cycles(input logic [31:0] n);
        return (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Divisor configuration: load handshake, pending slot, sticky error flag
// and the rule deciding when a pending divisor becomes active.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_valid,
    input  logic [CNT_W-1:0] div_value,
    output logic             div_ready,
    output logic             cfg_err,
    input  logic             running,
    input  logic             boundary,
    output logic [CNT_W-1:0] div_act,
    output logic [CNT_W-1:0] div_nxt
);

    logic             pend_v;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] div_q;
    logic             apply;
    logic             accept;

    // A pending value can only exist from an earlier edge, so an acceptance
    // edge that is also a boundary never applies the value it just accepted.
    assign apply     = pend_v && (boundary || !running);
    assign accept    = div_valid && !pend_v;
    assign div_ready = !pend_v;
    assign div_act   = div_q;
    assign div_nxt   = apply ? pend : div_q;

    // Pending slot, active divisor and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v  <= 1'b0;
            pend    <= '0;
            div_q   <= CNT_W'(DEFAULT_DIV);
            cfg_err <= 1'b0;
        end else begin
            if (apply) begin
                div_q  <= pend;
                pend_v <= 1'b0;
            end
            if (accept) begin
                if (div_legal(32'(div_value))) begin
                    pend   <= div_value;
                    pend_v <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free divisor changes,
// clean start/stop and a tick at each rising edge of out.
// Optional macro ODD_DUTY50_EN: odd divisors get 50% duty via a
// negedge-retimed copy of the output phase.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [CNT_W-1:0] div_value,
    output logic             out,
    output logic             tick,
    output logic             cfg_err
);

    logic [CNT_W-1:0] cnt, cnt_n;
    logic             running, run_n;
    logic             out_q, out_n, tick_n;
    logic [CNT_W-1:0] div_act, div_nxt, hi_n;
    logic             boundary;

    assign boundary = running && (cnt == div_act - CNT_W'(1));

    clk_div_cfg #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_cfg (
        .clk       (clk),
        .rst       (rst),
        .div_valid (div_valid),
        .div_value (div_value),
        .div_ready (div_ready),
        .cfg_err   (cfg_err),
        .running   (running),
        .boundary  (boundary),
        .div_act   (div_act),
        .div_nxt   (div_nxt)
    );

    // Next counter/run state; stop is only honoured at a period boundary,
    // and the output phase uses the divisor in force for the next cycle.
    always_comb begin
        run_n = running;
        cnt_n = cnt;
        if (!running) begin
            if (en) begin
                run_n = 1'b1;
                cnt_n = '0;
            end
        end else if (boundary) begin
            cnt_n = '0;
            run_n = en;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end
        hi_n   = CNT_W'(high_cycles(32'(div_nxt)));
        out_n  = run_n && (cnt_n < hi_n);
        tick_n = run_n && (cnt_n == '0);
    end

    // Counter, run flag and registered output phase and tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
            out_q   <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            running <= run_n;
            out_q   <= out_n;
            tick    <= tick_n;
        end
    end

`ifdef ODD_DUTY50_EN
    logic odd_q, out_neg;

    // Remember whether the current cycle belongs to an odd-divisor period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) odd_q <= 1'b0;
        else     odd_q <= run_n && div_nxt[0];
    end

    // Half-cycle stretch of the high phase for odd divisors.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) out_neg <= 1'b0;
        else     out_neg <= out_q && odd_q;
    end

    assign out = out_q | out_neg;
`else
    assign out = out_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: a period-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       div_valid = 1'b0;
    logic [7:0] div_value = 8'd0;
    logic       div_ready, out, tick, cfg_err;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    clk_div_prog #(.CNT_W(8), .DEFAULT_DIV(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_value (div_value),
        .out       (out),
        .tick      (tick),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: tracks when the current period started and its length.
    int m_t, m_start, m_n, m_pn;
    bit m_run, m_pv, m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_start = 0; m_n = 3; m_pn = 0;
            m_run = 0; m_pv = 0; m_err = 0;
        end else begin
            bit bnd, app;
            bnd = m_run && (m_t - m_start == m_n - 1);
            app = m_pv && (bnd || !m_run);
            if (app) begin
                m_n  = m_pn;
                m_pv = 0;
            end else if (div_valid && !m_pv) begin
                if (div_value < 2) m_err = 1;
                else begin m_pv = 1; m_pn = int'(div_value); end
            end
            m_t++;
            if (!m_run) begin
                if (en) begin m_run = 1; m_start = m_t; end
            end else if (bnd) begin
                if (en) m_start = m_t;
                else    m_run = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_out",   out,       m_run && ((m_t - m_start) < m_n / 2));
            chk("model_tick",  tick,      m_run && (m_t == m_start));
            chk("model_ready", div_ready, !m_pv);
            chk("model_err",   cfg_err,   m_err);
        end
    end

    // Returns number of edges waited until div_ready is high (bounded).
    task automatic wait_ready(output int k);
        k = 0;
        while (!div_ready && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) chk("ready_timeout", 0, 1);
    endtask

    // Offer a divisor and hold it until it transfers; entered and left #1 after posedge.
    task automatic send(input int v);
        int k;
        div_valid = 1'b1;
        div_value = v[7:0];
        wait_ready(k);
        @(posedge clk); #1;
        div_valid = 1'b0;
    endtask

    // Sample out/tick over six cycles starting in the cycle after the next posedge.
    task automatic pattern6(output logic [5:0] o, output logic [5:0] t);
        o = '0; t = '0;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            o = {o[4:0], out};
            t = {t[4:0], tick};
        end
    endtask

    initial begin
        logic [5:0] po, pt;
        logic [3:0] qo, qt;
        int k, ones, ticks;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_out", out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_ready", div_ready, 1);
        chk("rst_err", cfg_err, 0);

        // Default divisor 3: 1 high, 2 low; high one cycle after en.
        en = 1'b1;
        pattern6(po, pt);
        chk("div3_out", po, 6'b100100);
        chk("div3_tick", pt, 6'b100100);

        // Switch to 6, then request 4 mid-period.
        @(posedge clk); #1;
        send(6);
        wait_ready(k);
        repeat (2) begin @(posedge clk); #1; end
        send(4);
        chk("ready_drop", div_ready, 0);
        wait_ready(k);
        chk("apply_wait", k, 3);
        qo = '0; qt = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            qo = {qo[2:0], out};
            qt = {qt[2:0], tick};
        end
        chk("div4_out", qo, 4'b1100);
        chk("div4_tick", qt, 4'b1000);

        // Illegal divisors are swallowed and flagged.
        @(posedge clk); #1;
        send(1);
        chk("err_after_1", cfg_err, 1);
        chk("ready_after_1", div_ready, 1);
        send(0);
        chk("err_after_0", cfg_err, 1);
        repeat (10) begin @(posedge clk); #1; end
        chk("err_sticky", cfg_err, 1);

        // Divisor 8, drop en at cnt=2: remaining 2 high cycles, then silent.
        send(8);
        wait_ready(k);
        repeat (2) begin @(posedge clk); #1; end
        en = 1'b0;
        ones = 0; ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ones  += int'(out);
            ticks += int'(tick);
        end
        chk("stop_ones", ones, 2);
        chk("stop_ticks", ticks, 0);
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart_out", out, 1);
        chk("restart_tick", tick, 1);

        // Reset at cnt=3 with a pending load.
        @(posedge clk); #1;
        send(5);
        @(posedge clk);
        #2;
        chk("pre_rst_ready", div_ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", out, 0);
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_ready", div_ready, 1);
        chk("mid_rst_err", cfg_err, 0);
        en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        pattern6(po, pt);
        chk("post_rst_out", po, 6'b100100);
        chk("post_rst_tick", pt, 6'b100100);

        en = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
